// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile32 write-port controller.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_ctrl_state_t;

    localparam int RF_DW      = 32;
    localparam int RF_AW      = 5;
    localparam int RF_NREG    = 32;
    localparam int WR_COUNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] v);
        logic [WR_COUNT_W-1:0] r;
        if (v == {WR_COUNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(WR_COUNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Client handshake and regfile32 write-port bundle for regfile_wr_arbiter.
interface regfile_wr_arbiter_if
    import regfile_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
);
    logic                  c0_valid;
    logic                  c1_valid;
    logic [AW-1:0]         c0_addr;
    logic [AW-1:0]         c1_addr;
    logic [DW-1:0]         c0_data;
    logic [DW-1:0]         c1_data;
    logic                  c0_ready;
    logic                  c1_ready;
    logic                  rf_we;
    logic [AW-1:0]         rf_rw;
    logic [DW-1:0]         rf_busw;
    logic                  busy;
    logic                  last_gnt;
    logic [WR_COUNT_W-1:0] wr_count;

    modport master (
        output c0_valid, c1_valid, c0_addr, c1_addr, c0_data, c1_data,
        input  c0_ready, c1_ready, rf_we, rf_rw, rf_busw, busy, last_gnt, wr_count
    );

    modport slave (
        input  c0_valid, c1_valid, c0_addr, c1_addr, c0_data, c1_data,
        output c0_ready, c1_ready, rf_we, rf_rw, rf_busw, busy, last_gnt, wr_count
    );
endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Combinational two-requester round-robin picker; 'last' is the previous winner.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       win
);

    // Lone requester wins; on contention the requester that did not win last time goes.
    always_comb begin
        gnt = 2'b00;
        win = last;
        case (req)
            2'b01: begin
                gnt = 2'b01;
                win = 1'b0;
            end
            2'b10: begin
                gnt = 2'b10;
                win = 1'b1;
            end
            2'b11: begin
                if (last) begin
                    gnt = 2'b01;
                    win = 1'b0;
                end else begin
                    gnt = 2'b10;
                    win = 1'b1;
                end
            end
            default: begin
                gnt = 2'b00;
                win = last;
            end
        endcase
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile32 write port between two clients (round-robin, valid/ready).
// Define RF_INIT_CLEAR_EN to add a post-reset sweep that zeroes all NREG registers.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int DW   = RF_DW,
    parameter int AW   = RF_AW,
    parameter int NREG = RF_NREG
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wr_arbiter_if.slave bus
);

    if (NREG > (1 << AW)) begin : g_nreg_check
        $error("NREG does not fit in the register address space");
    end

    logic [1:0]            req_s;
    logic [1:0]            gnt_s;
    logic                  win_s;
    logic                  run_s;
    logic                  xfer_s;
    logic [AW-1:0]         win_addr_s;
    logic [DW-1:0]         win_data_s;
    logic                  rf_we_r;
    logic [AW-1:0]         rf_rw_r;
    logic [DW-1:0]         rf_busw_r;
    logic                  last_gnt_r;
    logic [WR_COUNT_W-1:0] wr_count_r;

`ifdef RF_INIT_CLEAR_EN
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    rf_ctrl_state_t state_r;
    logic [AW-1:0]  idx_r;
    assign run_s    = (state_r == RUN);
    assign bus.busy = (state_r == INIT);
`else
    assign run_s    = 1'b1;
    assign bus.busy = 1'b0;
`endif

    // Masking requests outside RUN keeps both readys low during the sweep.
    assign req_s = {bus.c1_valid, bus.c0_valid} & {2{run_s}};

    rr_arb2 u_arb (
        .req  (req_s),
        .last (last_gnt_r),
        .gnt  (gnt_s),
        .win  (win_s)
    );

    assign bus.c0_ready = gnt_s[0];
    assign bus.c1_ready = gnt_s[1];
    assign xfer_s       = |gnt_s;

    // Select the winning client's address and data.
    always_comb begin
        if (win_s) begin
            win_addr_s = bus.c1_addr;
            win_data_s = bus.c1_data;
        end else begin
            win_addr_s = bus.c0_addr;
            win_data_s = bus.c0_data;
        end
    end

    // Controller FSM plus registered write port, winner history and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_r    <= 1'b0;
            rf_rw_r    <= {AW{1'b0}};
            rf_busw_r  <= {DW{1'b0}};
            last_gnt_r <= 1'b1;
            wr_count_r <= {WR_COUNT_W{1'b0}};
`ifdef RF_INIT_CLEAR_EN
            state_r    <= INIT;
            idx_r      <= {AW{1'b0}};
`endif
        end else begin
`ifdef RF_INIT_CLEAR_EN
            if (state_r == INIT) begin
                rf_we_r   <= 1'b1;
                rf_rw_r   <= idx_r;
                rf_busw_r <= {DW{1'b0}};
                idx_r     <= idx_r + {{(AW-1){1'b0}}, 1'b1};
                if (idx_r == LAST_IDX) begin
                    state_r <= RUN;
                end else begin
                    state_r <= INIT;
                end
            end else
`endif
            if (xfer_s) begin
                rf_we_r    <= 1'b1;
                rf_rw_r    <= win_addr_s;
                rf_busw_r  <= win_data_s;
                last_gnt_r <= win_s;
                wr_count_r <= sat_inc(wr_count_r);
            end else begin
                rf_we_r <= 1'b0;
            end
        end
    end

    assign bus.rf_we    = rf_we_r;
    assign bus.rf_rw    = rf_rw_r;
    assign bus.rf_busw  = rf_busw_r;
    assign bus.last_gnt = last_gnt_r;
    assign bus.wr_count = wr_count_r;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed scoreboard bench for regfile_wr_arbiter with a behavioural regfile32 beside it.
// Sweep steps are compiled in when RF_INIT_CLEAR_EN is defined.
module tb_regfile_wr_arbiter;

    typedef struct packed {
        logic        we;
        logic [4:0]  rw;
        logic [31:0] busw;
    } exp_t;

`ifdef RF_INIT_CLEAR_EN
    localparam logic INIT_EN = 1'b1;
`else
    localparam logic INIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        preload = 1'b0;
    logic [31:0] rf_mem [32];
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;

    logic        m_init;
    logic [4:0]  m_idx;
    logic        m_last;
    logic [15:0] m_count;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;

    regfile_wr_arbiter_if #(.DW(32), .AW(5)) bus ();

    regfile_wr_arbiter #(.DW(32), .AW(5), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural regfile32 write port; preload fills it with nonzero junk.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hA5A5_0000 + i;
        end else if (bus.rf_we) begin
            rf_mem[bus.rf_rw] <= bus.rf_busw;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_c0(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.c0_valid = v;
        bus.c0_addr  = a;
        bus.c0_data  = d;
    endtask

    task automatic set_c1(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.c1_valid = v;
        bus.c1_addr  = a;
        bus.c1_data  = d;
    endtask

    task automatic do_reset();
        set_c0(1'b0, 5'd0, 32'h0);
        set_c1(1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_rf_we", bus.rf_we, 1'b0);
        check("rst_rf_rw", bus.rf_rw, 5'd0);
        check("rst_rf_busw", bus.rf_busw, 32'h0);
        check("rst_wr_count", bus.wr_count, 16'h0);
        check("rst_last_gnt", bus.last_gnt, 1'b1);
        check("rst_busy", bus.busy, INIT_EN);
        check("rst_c0_ready", bus.c0_ready, 1'b0);
        check("rst_c1_ready", bus.c1_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_init  = INIT_EN;
        m_idx   = 5'd0;
        m_last  = 1'b1;
        m_count = 16'h0;
        m_rw    = 5'd0;
        m_busw  = 32'h0;
        sb.delete();
        sb.push_back('{we: 1'b0, rw: 5'd0, busw: 32'h0});
    endtask

    // One clock: check outputs against the scoreboard, predict the next edge, advance.
    task automatic cycle();
        exp_t e;
        logic g0;
        logic g1;
        @(negedge clk);
        check("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rf_we", bus.rf_we, e.we);
            check("rf_rw", bus.rf_rw, e.rw);
            check("rf_busw", bus.rf_busw, e.busw);
        end
        check("busy", bus.busy, m_init);
        check("last_gnt", bus.last_gnt, m_last);
        check("wr_count", bus.wr_count, m_count);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!m_init) begin
            if (bus.c0_valid && bus.c1_valid) begin
                g0 = m_last;
                g1 = !m_last;
            end else begin
                g0 = bus.c0_valid;
                g1 = bus.c1_valid;
            end
        end
        check("c0_ready", bus.c0_ready, g0);
        check("c1_ready", bus.c1_ready, g1);
        if (m_init) begin
            m_rw   = m_idx;
            m_busw = 32'h0;
            sb.push_back('{we: 1'b1, rw: m_rw, busw: m_busw});
            if (m_idx == 5'd31) m_init = 1'b0;
            m_idx = m_idx + 5'd1;
        end else if (g0 || g1) begin
            m_rw   = g0 ? bus.c0_addr : bus.c1_addr;
            m_busw = g0 ? bus.c0_data : bus.c1_data;
            m_last = g1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            sb.push_back('{we: 1'b1, rw: m_rw, busw: m_busw});
        end else begin
            sb.push_back('{we: 1'b0, rw: m_rw, busw: m_busw});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_sweep();
        do_reset();
`ifdef RF_INIT_CLEAR_EN
        repeat (32) cycle();
`endif
    endtask

    initial begin
        set_c0(1'b0, 5'd0, 32'h0);
        set_c1(1'b0, 5'd0, 32'h0);
        preload = 1'b1;
        @(posedge clk);
        #1;
        preload = 1'b0;

        // Contention right after reset (and after the sweep when compiled in).
        reset_and_sweep();
`ifdef RF_INIT_CLEAR_EN
        cycle();
        for (int i = 0; i < 32; i++) check("swept_zero", rf_mem[i], 32'h0);
`endif
        set_c0(1'b1, 5'd0, 32'h0000_00C0);
        set_c1(1'b1, 5'd2, 32'h0000_00C1);
        repeat (6) cycle();
        set_c0(1'b0, 5'd0, 32'h0);
        set_c1(1'b0, 5'd0, 32'h0);
        cycle();
        cycle();
        check("contend_count", bus.wr_count, 16'd6);
        check("contend_last", bus.last_gnt, 1'b1);
        check("contend_r0", rf_mem[0], 32'h0000_00C0);
        check("contend_r2", rf_mem[2], 32'h0000_00C1);

        // Single client c1 writes r7.
        reset_and_sweep();
        set_c1(1'b1, 5'd7, 32'hDEAD_BEEF);
        cycle();
        set_c1(1'b0, 5'd0, 32'h0);
        cycle();
        cycle();
        check("single_r7", rf_mem[7], 32'hDEAD_BEEF);
        check("single_count", bus.wr_count, 16'd1);
        check("single_last", bus.last_gnt, 1'b1);

        // Same-address collision with c0 as the previous winner.
        set_c0(1'b1, 5'd9, 32'h0000_0055);
        cycle();
        set_c0(1'b1, 5'd3, 32'h0000_0011);
        set_c1(1'b1, 5'd3, 32'h0000_0022);
        cycle();
        set_c1(1'b0, 5'd0, 32'h0);
        cycle();
        set_c0(1'b0, 5'd0, 32'h0);
        cycle();
        cycle();
        check("collide_r3", rf_mem[3], 32'h0000_0011);
        check("collide_r9", rf_mem[9], 32'h0000_0055);
        check("collide_count", bus.wr_count, 16'd4);

`ifdef RF_INIT_CLEAR_EN
        // Reset in the middle of the sweep restarts it from zero.
        do_reset();
        repeat (12) cycle();
        check("midsweep_we_before", bus.rf_we, 1'b1);
        do_reset();
        repeat (32) cycle();
        cycle();
        check("midsweep_busy_after", bus.busy, 1'b0);
`endif

        // Saturation of the transfer counter.
        reset_and_sweep();
        set_c0(1'b1, 5'd5, 32'h5A5A_5A5A);
        repeat (65540) cycle();
        set_c0(1'b0, 5'd0, 32'h0);
        cycle();
        check("sat_count", bus.wr_count, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
